ysyx_25030081_rf_sb: RTL
========================

# ysyx_25030081_rf_sb

Parametrised integer register file with an integrated per-register write scoreboard, for the pipelined NPC core. Provides NR_RD combinational read ports and one writeback port, keeps x0 hardwired to zero, and tracks outstanding writes per architectural register so decode can stall on RAW hazards. Sits between decode/issue, which reads operands and reserves rd, and writeback, which writes and releases rd.

## Interface
- RF_ADDR_WIDTH, 5: register index width; 4 gives RV32E (16 registers).
- DATA_WIDTH, 32: register width.
- NR_RD, 2: number of read ports.
- CNT_WIDTH, 2: per-register pending-write counter width; max outstanding writes per register = 2**CNT_WIDTH-1.
- clk  in  1  sole clock; all state updates on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- rd_addr  in  NR_RD*RF_ADDR_WIDTH  packed read addresses; port i at [i*AW +: AW].
- rd_data  out  NR_RD*DATA_WIDTH  packed read data, combinational.
- rd_busy  out  NR_RD  port i source has an outstanding write; combinational.
- iss_valid  in  1  issue reserves destination iss_rd.
- iss_rd  in  RF_ADDR_WIDTH  destination register being reserved.
- iss_ready  out  1  reservation accepted this cycle; combinational.
- wb_valid  in  1  writeback: write wb_data and release one reservation of wb_addr.
- wb_addr  in  RF_ADDR_WIDTH  writeback register.
- wb_data  in  DATA_WIDTH  writeback data.
- flush  in  1  clear all reservations (pipeline squash).
- sb_err  out  1  registered one-cycle pulse on release of a register with count 0.

## Operation
- Storage: 2**RF_ADDR_WIDTH entries × DATA_WIDTH. Entry 0 is never written and always reads 0. Its counter is always 0 and never busy.
- Read: rd_data[i] = 0 if rd_addr[i]==0, else array[rd_addr[i]] (bypass per Configuration).
- rd_busy[i] = (cnt[rd_addr[i]] != 0). Always 0 for address 0.
- iss_ready = (iss_rd==0) || (cnt[iss_rd] != max). The decision is conservative and ignores a same-cycle release.
- Reservation fires when iss_valid && iss_ready && iss_rd!=0. Release fires when wb_valid && wb_addr!=0.
- Counter update per register r: +1 on reservation of r, −1 on release of r. Both in the same cycle leave it unchanged. Release at 0 keeps 0 and sets sb_err next cycle. The counter never wraps.
- Data write on wb_valid && wb_addr!=0, regardless of counter value or flush.
- flush: all counters become 0 next edge. Same-cycle reservation and release are ignored for counters. Same-cycle wb data is still written.

## Timing
- Reset, asynchronous on rst_n low: all array entries 0, all counters 0, sb_err 0. rd_busy is 0 and iss_ready is 1 while in reset.
- Reads and rd_busy: 0-cycle combinational. iss_ready: combinational from iss_rd.
- A write at edge N is visible on rd_data after edge N. Counters and busy update after edge N.
- Reservation at edge N makes rd_busy assert for that register from the cycle after N.
- sb_err is high for exactly the one cycle after the offending edge.
- If reset asserts mid-operation, all reservations are lost and contents are cleared. Writeback in flight during reset is dropped.

## Configuration
- YSYX_25030081_RF_BYPASS_EN defined: write-to-read forwarding is enabled.
  - When wb_valid && wb_addr==rd_addr[i]!=0, rd_data[i]=wb_data.
  - rd_busy[i] = (cnt − 1 != 0) for that register, so the last outstanding write unblocks the reader in the same cycle.
- Not defined: no forwarding. rd_data comes from the array only, and rd_busy[i] = cnt!=0. Readers see writeback data one cycle later.

## Structure
- Package ysyx_25030081_rf_pkg holds the default widths (RF_ADDR_WIDTH, DATA_WIDTH, CNT_WIDTH, NR_RD) and the count-max constant, shared with decode and writeback.
- Sub-module ysyx_25030081_sb_cnt holds one saturating up/down counter with flush and an underflow flag. It is instantiated 2**RF_ADDR_WIDTH−1 times in a generate loop.

## Test plan
- Reset, then read all 32 registers on both ports → all 0, rd_busy=0, iss_ready=1. Write x0=0xDEADBEEF → x0 still reads 0.
- Issue x5, then x5 → cnt 2, rd_busy=1 on a port reading 5. wb x5=0x11 → still busy. wb x5=0x22 → not busy, reads 0x22.
- With CNT_WIDTH=2, three issues to x7 → fourth cycle iss_ready=0 for iss_rd=7, but 1 for iss_rd=8.
- Same-cycle issue and wb of x9 with cnt 1 → cnt stays 1, data written. flush with cnt x9=1 and same-cycle issue x9 → cnt 0.
- Bypass on: cnt x3=1, wb x3=0xA5A5 with rd_addr=3 → rd_data=0xA5A5 and rd_busy=0 in the same cycle. Bypass off: old value and busy=1, then 0xA5A5 next cycle.
- wb x4 with cnt 0 → sb_err pulses one cycle and data is written. Assert rst_n low mid-sequence → all counters and data 0 immediately.

Source files
------------

// File: rtl/ysyx_25030081_rf_sb_pkg.sv
// Shared defaults for the integer register file and its write scoreboard.
// Latency: n/a (constants and helpers only).
// Backpressure: n/a.
// Consumers: decode/issue, writeback and the register file itself import this
// package so that register width, index width and scoreboard depth agree.
package ysyx_25030081_rf_pkg;

  localparam int RF_ADDR_WIDTH = 5;   // 4 selects the 16-register RV32E file
  localparam int DATA_WIDTH    = 32;
  localparam int NR_RD         = 2;
  localparam int CNT_WIDTH     = 2;

  // Largest number of outstanding writes a CNT_WIDTH-bit counter can track.
  function automatic int cnt_max(input int w);
    return (1 << w) - 1;
  endfunction

  localparam int CNT_MAX = cnt_max(CNT_WIDTH);

endpackage

// File: rtl/ysyx_25030081_rf_sb_if.sv
// Operand-read / issue-reserve / writeback bundle between the pipeline and the
// register file. Reads and iss_ready are combinational on the slave side.
// Backpressure: iss_ready refuses a reservation once the rd counter is full.
// Ports: rd_addr/rd_data/rd_busy (NR_RD read ports, packed, port i at slice i),
//        iss_valid/iss_rd/iss_ready (reserve rd), wb_valid/wb_addr/wb_data
//        (write and release), flush (drop all reservations), sb_err (underflow).
interface ysyx_25030081_rf_sb_if #(
  parameter int RF_ADDR_WIDTH = ysyx_25030081_rf_pkg::RF_ADDR_WIDTH,
  parameter int DATA_WIDTH    = ysyx_25030081_rf_pkg::DATA_WIDTH,
  parameter int NR_RD         = ysyx_25030081_rf_pkg::NR_RD
);

  logic [NR_RD*RF_ADDR_WIDTH-1:0] rd_addr;
  logic [NR_RD*DATA_WIDTH-1:0]    rd_data;
  logic [NR_RD-1:0]               rd_busy;
  logic                           iss_valid;
  logic [RF_ADDR_WIDTH-1:0]       iss_rd;
  logic                           iss_ready;
  logic                           wb_valid;
  logic [RF_ADDR_WIDTH-1:0]       wb_addr;
  logic [DATA_WIDTH-1:0]          wb_data;
  logic                           flush;
  logic                           sb_err;

  // Pipeline side: decode/issue and writeback.
  modport master (
    output rd_addr, iss_valid, iss_rd, wb_valid, wb_addr, wb_data, flush,
    input  rd_data, rd_busy, iss_ready, sb_err
  );

  // Register file side.
  modport slave (
    input  rd_addr, iss_valid, iss_rd, wb_valid, wb_addr, wb_data, flush,
    output rd_data, rd_busy, iss_ready, sb_err
  );

endinterface

// File: rtl/ysyx_25030081_sb_cnt.sv
// Saturating up/down pending-write counter for one architectural register.
// Latency: count updates on the edge after inc/dec/flush; underflow is combinational.
// Backpressure: none here; the owner must not inc at max (it saturates if it does).
// Ports: clk, rst_n, inc (reserve), dec (release), flush (clear),
//        cnt (current count), underflow (release seen while count is zero).
module ysyx_25030081_sb_cnt #(
  parameter int CNT_WIDTH = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 inc,
  input  logic                 dec,
  input  logic                 flush,
  output logic [CNT_WIDTH-1:0] cnt,
  output logic                 underflow
);

  localparam logic [CNT_WIDTH-1:0] CMAX = '1;
  localparam logic [CNT_WIDTH-1:0] ONE  = 1;

  // Flush wins over any same-cycle reserve/release; a simultaneous reserve and
  // release cancel out; the counter neither wraps up nor down.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (flush) begin
      cnt <= '0;
    end else if (inc && !dec && cnt != CMAX) begin
      cnt <= cnt + ONE;
    end else if (dec && !inc && cnt != '0) begin
      cnt <= cnt - ONE;
    end
  end

  // Releasing a register nobody reserved is a pipeline bookkeeping bug.
  assign underflow = dec && (cnt == '0);

endmodule

// File: rtl/ysyx_25030081_rf_sb.sv
// Integer register file (x0 = 0) with per-register pending-write scoreboard.
// Latency: reads/rd_busy/iss_ready combinational; writes and counters after the edge.
// Backpressure: iss_ready drops when the requested rd already has max writes pending.
// Ports: clk, rst_n (async, active low), bus (slave side of ysyx_25030081_rf_sb_if).
// Option: define YSYX_25030081_RF_BYPASS_EN to forward same-cycle writeback data
// to readers and let the last outstanding write unblock them in that cycle.
module ysyx_25030081_rf_sb #(
  parameter int RF_ADDR_WIDTH = ysyx_25030081_rf_pkg::RF_ADDR_WIDTH,
  parameter int DATA_WIDTH    = ysyx_25030081_rf_pkg::DATA_WIDTH,
  parameter int NR_RD         = ysyx_25030081_rf_pkg::NR_RD,
  parameter int CNT_WIDTH     = ysyx_25030081_rf_pkg::CNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  ysyx_25030081_rf_sb_if.slave  bus
);

  import ysyx_25030081_rf_pkg::*;

  localparam int NREG = 1 << RF_ADDR_WIDTH;
  localparam logic [CNT_WIDTH-1:0] CNT_SAT = CNT_WIDTH'(cnt_max(CNT_WIDTH));

  logic [DATA_WIDTH-1:0] mem [NREG];
  logic [CNT_WIDTH-1:0]  cnt [NREG];
  logic [NREG-1:0]       uflow;
  logic                  iss_fire;
  logic                  wb_fire;
  logic                  sb_err_q;

  // Readiness looks only at the current count, not at a same-cycle release,
  // so it never depends on wb_* timing.
  assign bus.iss_ready = (bus.iss_rd == '0) || (cnt[bus.iss_rd] != CNT_SAT);
  assign iss_fire      = bus.iss_valid && bus.iss_ready && (bus.iss_rd != '0);
  assign wb_fire       = bus.wb_valid && (bus.wb_addr != '0);

  // x0 has no counter: never busy, never reserved, never underflows.
  assign cnt[0]   = '0;
  assign uflow[0] = 1'b0;

  for (genvar r = 1; r < NREG; r++) begin : g_cnt
    ysyx_25030081_sb_cnt #(
      .CNT_WIDTH (CNT_WIDTH)
    ) u_cnt (
      .clk       (clk),
      .rst_n     (rst_n),
      .inc       (iss_fire && (bus.iss_rd == RF_ADDR_WIDTH'(r))),
      .dec       (wb_fire && (bus.wb_addr == RF_ADDR_WIDTH'(r))),
      .flush     (bus.flush),
      .cnt       (cnt[r]),
      .underflow (uflow[r])
    );
  end

  // Data is written whenever writeback fires, whatever the counter or flush say.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NREG; k++) begin
        mem[k] <= '0;
      end
    end else if (wb_fire) begin
      mem[bus.wb_addr] <= bus.wb_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb_err_q <= 1'b0;
    end else begin
      sb_err_q <= |uflow;
    end
  end

  assign bus.sb_err = sb_err_q;

  for (genvar i = 0; i < NR_RD; i++) begin : g_rd
    logic [RF_ADDR_WIDTH-1:0] a;
    logic [CNT_WIDTH-1:0]     c;
    assign a = bus.rd_addr[i*RF_ADDR_WIDTH +: RF_ADDR_WIDTH];
    assign c = cnt[a];
`ifdef YSYX_25030081_RF_BYPASS_EN
    localparam logic [CNT_WIDTH-1:0] ONE = 1;
    logic hit;
    // wb_fire already excludes x0, so a hit implies a != 0.
    assign hit = wb_fire && (bus.wb_addr == a);
    assign bus.rd_data[i*DATA_WIDTH +: DATA_WIDTH] =
      (a == '0) ? '0 : (hit ? bus.wb_data : mem[a]);
    // The retiring write counts as done; c > 1 rather than c - 1 != 0 so an
    // erroneous release at count 0 does not spuriously mark the reader busy.
    assign bus.rd_busy[i] = hit ? (c > ONE) : (c != '0);
`else
    assign bus.rd_data[i*DATA_WIDTH +: DATA_WIDTH] = (a == '0) ? '0 : mem[a];
    assign bus.rd_busy[i] = (c != '0);
`endif
  end

endmodule
